uart_tx: RTL

UART transmitter that serialises bytes onto an 8N1 line at a fixed baud rate derived from the system clock. It is the transmit half of the design's UART link and pairs with the existing receiver, so it guarantees one idle bit between consecutive frames. A small FIFO decouples the byte producer (string/command logic) from the bit-serial line, with a valid/ready handshake. Nominal use is a 50 MHz clock at 115200 baud.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_if.sv | 9 +
 rtl/uart_tx_fifo.sv | 52 +++++
 rtl/uart_tx.sv | 105 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, frame bit counts and baud divisor helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4
  } state_t;

  // Clocks per bit, truncated (434 for 50 MHz / 115200).
  function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte producer to transmitter handshake (valid/ready).
interface uart_tx_if;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;

  modport master (output in_valid, output in_byte, input in_ready);
  modport slave  (input in_valid, input in_byte, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous circular byte FIFO; pointers wrap modulo DEPTH (power of two).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] dout,
  output logic [CNT_W-1:0]     count,
  output logic                 full
);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with input FIFO and one idle bit time between frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter  int unsigned CLK_FREQ   = 50_000_000,
  parameter  int unsigned BAUD       = 115200,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned FC_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rstn,
  uart_tx_if.slave        in_if,
  output logic            tx,
  output logic            busy,
  output logic            byte_done,
  output logic [FC_W-1:0] fifo_count
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned IDX_W    = $clog2(DATA_BITS);

  state_t                 state;
  logic [CNT_W-1:0]       baud_cnt;
  logic [IDX_W-1:0]       bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic [DATA_BITS-1:0]   fifo_dout;
  logic                   fifo_full;
  logic                   push;
  logic                   pop;
  logic                   bit_end;

  assign in_if.in_ready = !fifo_full;
  assign push           = in_if.in_valid && !fifo_full;
  assign pop            = (state == IDLE) && (fifo_count != '0);
  assign bit_end        = (baud_cnt == CNT_W'(BAUD_DIV - 1));
  assign busy           = (state != IDLE) || (fifo_count != '0);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (in_if.in_byte),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full)
  );

  // Frame sequencer: baud counter, shift register and registered line output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      tx        <= 1'b1;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (state != IDLE) baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg    <= fifo_dout;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx    <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
              tx      <= shreg[1];
            end
          end
        end
        STOP: begin
          if (bit_end) state <= GAP;
        end
        GAP: begin
          if (bit_end) begin
            byte_done <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
